// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//
// Select-line sequencer for a 4:1 mux tree. It walks the enabled channels of a
// latched mask. On each channel it holds the select lines for DWELL cycles so
// the mux output can settle, then captures mux_y. The captured value goes
// downstream as a {channel, data} sample over a valid/ready handshake.
// Scans are either one-shot (one pass over the mask) or continuous (wrapping
// passes until stop is requested).
//
// Parameters
//   DWELL  cycles the select lines are held before capture (1..15)
//   W      width of mux_y / out_data
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a scan (only honoured in IDLE)
//   cont       1 = continuous scan, 0 = one-shot (latched with start)
//   stop       continuous mode: finish after the current sample handshake
//   ch_mask    enabled channels, bit k = mux input k (latched with start)
//   sel0/sel1  mux select lines, {sel0, sel1} = channel index
//   mux_y      mux output being sampled
//   out_valid  sample available
//   out_ready  downstream accepts the sample
//   out_data   captured mux_y
//   out_ch     channel index of out_data
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse when a scan ends
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int DWELL = 3,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cont,
  input  logic         stop,
  input  logic [3:0]   ch_mask,
  output logic         sel0,
  output logic         sel1,
  input  logic [W-1:0] mux_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_ch,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t     state;
  logic [1:0] ch;
  logic [3:0] cnt;
  logic [3:0] mask_q;
  logic       cont_q;
  logic       stop_req;

  // Channel search helpers. Both return {found, index}.
  function automatic logic [2:0] lowest_set(input logic [3:0] m);
    lowest_set = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) lowest_set = {1'b1, 2'(k)};
    end
  endfunction

  function automatic logic [2:0] next_above(input logic [3:0] m,
                                            input logic [1:0] c);
    next_above = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (k > int'(c))) next_above = {1'b1, 2'(k)};
    end
  endfunction

  logic [2:0] start_first;
  logic [2:0] wrap_first;
  logic [2:0] above;
  logic       end_scan;

  always_comb begin
    start_first = lowest_set(ch_mask);
    wrap_first  = lowest_set(mask_q);
    above       = next_above(mask_q, ch);
    // Continuous scans end only on a stop request (including one arriving in
    // the handshake cycle itself); one-shot scans end after the highest
    // enabled channel.
    if (cont_q) end_scan = stop_req | stop;
    else        end_scan = ~above[2];
  end

  // Select lines follow the registered channel directly, so they change only
  // on the edge that moves to a new channel.
  assign sel0 = ch[1];
  assign sel1 = ch[0];
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ch        <= 2'd0;
      cnt       <= 4'd0;
      mask_q    <= 4'd0;
      cont_q    <= 1'b0;
      stop_req  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= 2'd0;
    end else begin
      if (busy) stop_req <= stop_req | stop;

      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q   <= ch_mask;
            cont_q   <= cont;
            stop_req <= 1'b0;
            cnt      <= 4'd0;
            if (ch_mask == 4'd0) begin
              state <= S_DONE;
            end else begin
              ch    <= start_first[1:0];
              state <= S_SETTLE;
            end
          end
        end

        // settle -> capture boundary: mux_y sampled after DWELL cycles on ch
        S_SETTLE: begin
          if (cnt == 4'(DWELL - 1)) begin
            out_data  <= mux_y;
            out_ch    <= ch;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        // capture -> handshake boundary: everything frozen until accepted
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= 4'd0;
            if (end_scan) begin
              state <= S_DONE;
            end else begin
              ch    <= above[2] ? above[1:0] : wrap_first[1:0];
              state <= S_SETTLE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
//
// Randomised scoreboard bench. The driver works out, from the mask, mode and
// the number of samples before stop, which {channel, data} samples a scan must
// produce and queues them. A separate monitor pops one entry per handshake
// and also checks busy/done timing, hold stability and sample cadence.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;
  localparam int DWELL = 3;
  localparam int W     = 1;
  localparam int BIG   = 32'h3fff_ffff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cont = 1'b0;
  logic         stop = 1'b0;
  logic [3:0]   ch_mask = 4'd0;
  logic         sel0, sel1;
  logic [W-1:0] mux_y;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   out_ch;
  logic         busy, done;

  // Behavioural 4:1 mux: input k carries bit k of ivec.
  logic [3:0]   ivec = 4'h5;
  assign mux_y = W'(ivec[{sel0, sel1}]);

  mux_scan_ctrl #(.DWELL(DWELL), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
    .ch_mask(ch_mask), .sel0(sel0), .sel1(sel1), .mux_y(mux_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]   ch;
    logic [W-1:0] data;
  } smp_t;

  smp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         hs_count = 0;
  int         start_edge = -10;
  int         done_edge = -10;
  int         last_ref = 0;
  bit         ready_always = 1'b1;
  int         stall_left = 0;
  logic [3:0] m_mask = 4'd0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Downstream ready: either always high or random with stall bursts.
  initial begin : ready_drv
    forever begin
      @(negedge clk);
      if (ready_always) begin
        out_ready = 1'b1;
      end else if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 3) == 0) begin
        stall_left = $urandom_range(1, 6);
        out_ready  = 1'b0;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: looks #1 after the falling edge, when both DUT outputs and
  // bench inputs are stable for the coming rising edge.
  initial begin : monitor
    bit           pv;
    logic [1:0]   pch;
    logic [1:0]   psel;
    logic [W-1:0] pd;
    smp_t         e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        chk("busy", busy, (cyc >= start_edge) && (cyc <= done_edge));
        chk("done", done, cyc == done_edge);
        if (busy && m_mask != 4'd0) chk("sel_in_mask", m_mask[{sel0, sel1}], 1);
        if (pv) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, pd);
          chk("hold_ch", out_ch, pch);
          chk("hold_sel", {sel0, sel1}, psel);
        end
        if (out_valid) chk("sel_eq_ch", {sel0, sel1}, out_ch);
        if (out_valid && q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid at edge %0d: ch=%0d data=%0h, no sample expected",
                   cyc, out_ch, out_data);
        end else if (out_valid && out_ready) begin
          e = q.pop_front();
          chk("sample_ch", out_ch, e.ch);
          chk("sample_data", out_data, e.data);
          if (ready_always) chk("cadence", cyc + 1, last_ref + DWELL + 1);
          last_ref = cyc + 1;
          hs_count++;
          if (q.size() == 0) done_edge = cyc + 1;
        end
        if (out_valid && !out_ready) begin
          pv   = 1'b1;
          pch  = out_ch;
          pd   = out_data;
          psel = {sel0, sel1};
        end else begin
          pv = 1'b0;
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    q.delete();
    start_edge = -10;
    done_edge  = -10;
    #1;
    chk("rst_sel", {sel0, sel1}, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One scan. n_extra: continuous mode stops after n_extra+1 samples.
  // abort_after >= 0: reset once that many samples have been accepted.
  task automatic run_scan(input logic [3:0] m, input bit c, input int n_extra,
                          input bit noise, input bit rdy1, input int iv,
                          input int abort_after);
    int   base;
    int   k;
    int   total;
    int   en[$];
    smp_t s;
    @(negedge clk);
    ready_always = rdy1;
    ivec = (iv < 0) ? 4'($urandom) : 4'(iv);
    for (int i = 0; i < 4; i++) if (m[i]) en.push_back(i);
    if (m != 4'd0) begin
      total = c ? n_extra + 1 : en.size();
      for (int i = 0; i < total; i++) begin
        s.ch   = 2'(en[i % en.size()]);
        s.data = W'(ivec[s.ch]);
        q.push_back(s);
      end
    end
    m_mask     = m;
    base       = hs_count;
    start_edge = cyc + 1;
    last_ref   = cyc + 1;
    done_edge  = (m == 4'd0) ? cyc + 1 : BIG;
    ch_mask    = m;
    cont       = c;
    start      = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    ch_mask = 4'($urandom);
    cont    = 1'($urandom);

    if (abort_after >= 0) begin
      k = 0;
      while (hs_count < base + abort_after && k < 3000) begin
        @(negedge clk);
        k++;
      end
      if (k >= 3000) begin
        checks++;
        errors++;
        $display("FAIL abort_wait timeout: got %0d samples, required %0d",
                 hs_count - base, abort_after);
      end
      apply_reset();
      return;
    end

    if (c && m != 4'd0) begin
      k = 0;
      while (hs_count < base + n_extra && k < 3000) begin
        @(negedge clk);
        k++;
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end

    k = 0;
    while (!(done_edge != BIG && cyc > done_edge) && k < 3000) begin
      start = 1'b0;
      stop  = 1'b0;
      if (noise && ((busy && !out_valid && q.size() > 0) || cyc == done_edge)
          && $urandom_range(0, 3) == 0) start = 1'b1;
      if (noise && !c && $urandom_range(0, 3) == 0) stop = 1'b1;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    stop  = 1'b0;
    if (k >= 3000) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: got %0d samples, %0d still expected",
               hs_count - base, q.size());
      apply_reset();
    end
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (2) @(negedge clk);
    #1;
    chk("init_sel", {sel0, sel1}, 0);
    chk("init_valid", out_valid, 0);
    chk("init_data", out_data, 0);
    chk("init_ch", out_ch, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full one-shot pass over i3..i0 = 4'h5: (0,1),(1,0),(2,1),(3,0).
    run_scan(4'hF, 1'b0, 0, 1'b0, 1'b1, 5, -1);
    // Sparse mask: only channels 1 and 3.
    run_scan(4'hA, 1'b0, 0, 1'b0, 1'b1, 5, -1);
    // Backpressure bursts on a full pass.
    run_scan(4'hF, 1'b0, 0, 1'b0, 1'b0, 5, -1);
    // Empty mask, with start pulses during DONE.
    run_scan(4'h0, 1'b0, 0, 1'b1, 1'b1, 5, -1);
    // Continuous with wrap; stop raised in the second ch1 settle.
    run_scan(4'hF, 1'b1, 5, 1'b0, 1'b1, 5, -1);
    // Continuous, single channel: re-settles each time.
    run_scan(4'h4, 1'b1, 3, 1'b0, 1'b1, -1, -1);
    // Reset during the ch2 settle, then a fresh scan starts at ch0.
    run_scan(4'hF, 1'b0, 0, 1'b0, 1'b1, 5, 2);
    run_scan(4'hF, 1'b0, 0, 1'b0, 1'b1, 5, -1);

    for (int i = 0; i < 30; i++) begin
      run_scan(4'($urandom), 1'($urandom), $urandom_range(0, 8),
               1'($urandom), ($urandom_range(0, 2) == 0), -1, -1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
